mux_nto1_scan: RTL and testbench
================================

// Module: mux_nto1_scan
// PURPOSE
//  Registered, parametrised N-to-1 multiplexer for the DE1-SoC lab designs: selects one of CHANNELS W-bit inputs.
//  Channel selection is either manual (sel_in) or automatic round-robin scan with a programmable dwell time.
//  Sits between switch/bus sources and LED/HEX display drivers; hold freezes the displayed channel.
// PARAMETERS
//  WIDTH     4    bits per channel
//  CHANNELS  4    number of input channels, >=2; need not be a power of two
//  DWELL     50000000  clock cycles spent on each channel in scan mode (1 s at 50 MHz), >=1
//  SEL_W     localparam = max(1,$clog2(CHANNELS)); CNT_W localparam = max(1,$clog2(DWELL))
// PORTS
//  Clock         in   1                 single system clock, rising edge
//  Resetn        in   1                 synchronous reset, active-low
//  data_in       in   CHANNELS*WIDTH    channel k occupies [k*WIDTH +: WIDTH]
//  sel_in        in   SEL_W             manual channel select
//  mode          in   1                 0 = manual, 1 = scan
//  hold          in   1                 1 = freeze channel, output and dwell counter
//  data_out      out  WIDTH             registered selected data
//  chan_out      out  SEL_W             channel currently driving data_out
//  switch_pulse  out  1                 one-cycle strobe when chan_out changes value
// BEHAVIOUR
//  Reset (Resetn=0 at edge): state=MANUAL, chan=0, dwell cnt=0, data_out=0, chan_out=0, switch_pulse=0.
//  States: MANUAL, SCAN, FROZEN. Evaluated each rising edge, priority top-down:
//   - hold=1 (any state) -> FROZEN; chan, cnt, data_out unchanged; switch_pulse=0.
//   - FROZEN & hold=0 -> MANUAL or SCAN per mode sampled that cycle; cnt kept (scan resumes mid-dwell).
//   - MANUAL & mode=1 -> SCAN; cnt cleared to 0; scan starts from current chan.
//   - SCAN & mode=0 -> MANUAL; manual select rules apply that same edge.
//  MANUAL: chan <= sel_in if sel_in < CHANNELS; otherwise chan unchanged (out-of-range ignored).
//  SCAN: cnt increments each cycle; at cnt==DWELL-1 cnt<=0 and chan<=chan+1, wrapping CHANNELS-1 -> 0.
//   DWELL=1 -> advance every cycle.
//  data_out <= data_in[next_chan*WIDTH +: WIDTH] every non-held cycle: latency 1 cycle from data_in or
//   select change to data_out; data_out and chan_out always update on the same edge (coherent pair).
//  switch_pulse <= (next_chan != chan); asserted exactly the cycle chan_out shows the new value.
//  Simultaneous hold and mode change: hold wins; mode takes effect on the hold-release edge.
//  Reset mid-dwell or mid-hold: full reset values above; no residual pulse.
//  No combinational path from any input to any output.
// STRUCTURE
//  Package mux_nto1_scan_pkg: state enum (MANUAL, SCAN, FROZEN), MODE_MANUAL/MODE_SCAN constants.
//  Sub-module dwell_timer (params DWELL, CNT_W; ports Clock, Resetn, clr, en, tick): owns cnt,
//   tick asserted when cnt==DWELL-1 and en=1. Top holds FSM, chan register, output mux/registers.
// TESTING  (WIDTH=4, CHANNELS=3, DWELL=3 unless noted)
//  1 Reset: hold Resetn=0 two edges with mode=1 -> data_out=0, chan_out=0, switch_pulse=0.
//  2 Manual: data_in={4'hC,4'hB,4'hA}, sel_in=2 -> next edge data_out=4'hC, chan_out=2, pulse 1 cycle;
//    sel_in=3 (out of range) -> chan_out stays 2, no pulse.
//  3 Scan wrap: mode=1 from chan 0 -> chan_out 0,1,2,0 each held 3 cycles, data_out A,B,C,A, pulse per step.
//  4 Hold mid-dwell: hold=1 one cycle into chan 1 for 10 cycles -> outputs frozen, no pulse;
//    release -> chan 2 reached after remaining 2 cycles.
//  5 Hold+mode simultaneous: in SCAN assert hold=1 and mode=0 same edge -> FROZEN;
//    release with sel_in=0 -> MANUAL, chan_out=0.
//  6 DWELL=1, CHANNELS=4: scan -> chan_out 0,1,2,3,0 on consecutive edges, switch_pulse continuously 1.

Source files
------------

// File: rtl/mux_nto1_scan_pkg.sv
// Shared types and constants for the scanning N-to-1 multiplexer.
package mux_nto1_scan_pkg;

  typedef enum logic [1:0] {
    StManual = 2'd0,
    StScan   = 2'd1,
    StFrozen = 2'd2
  } state_e;

  localparam logic ModeManual = 1'b0;
  localparam logic ModeScan   = 1'b1;

endpackage

// File: rtl/mux_nto1_scan_dwell_timer.sv
// Dwell counter: counts enabled cycles and strobes tick on the last cycle of each dwell period.
module mux_nto1_scan_dwell_timer #(
  parameter int unsigned DWELL = 50000000,
  parameter int unsigned CNT_W = 26
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LastCnt);

  // Clear has priority over counting; wrap to zero on the final dwell cycle.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 multiplexer with manual select, round-robin scan and freeze.
module mux_nto1_scan
  import mux_nto1_scan_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 50000000,
  localparam int unsigned SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1,
  localparam int unsigned CNT_W   = (DWELL > 2) ? $clog2(DWELL) : 1
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          data_out,
  output logic [SEL_W-1:0]          chan_out,
  output logic                      switch_pulse
);

  // One extra bit so the range check also works when CHANNELS is a power of two.
  localparam logic [SEL_W:0]   ChanLim  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] ChanLast = SEL_W'(CHANNELS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] chan_q, chan_d, chan_inc;
  logic [WIDTH-1:0] data_q, sel_data;
  logic             pulse_q;
  logic             cnt_clr, scan_en, tick;

  mux_nto1_scan_dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (cnt_clr),
    .en     (scan_en),
    .tick   (tick)
  );

  assign chan_inc = (chan_q == ChanLast) ? '0 : chan_q + SEL_W'(1);

  // Next state and next channel; hold overrides any mode change.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    cnt_clr = 1'b0;
    scan_en = 1'b0;
    if (hold) begin
      state_d = StFrozen;
    end else if (mode == ModeScan) begin
      state_d = StScan;
      if (state_q == StManual) begin
        // Fresh scan entry: restart the dwell from the current channel.
        cnt_clr = 1'b1;
      end else begin
        // Running scan, or release from freeze resuming mid-dwell.
        scan_en = 1'b1;
        if (tick) chan_d = chan_inc;
      end
    end else begin
      state_d = StManual;
      if ({1'b0, sel_in} < ChanLim) chan_d = sel_in;
    end
  end

  // Data for the channel that will be shown after this edge.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (chan_d == SEL_W'(k)) sel_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  // FSM state plus registered channel, data and switch strobe updated together.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= StManual;
      chan_q  <= '0;
      data_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= !hold && (chan_d != chan_q);
      if (!hold) begin
        chan_q <= chan_d;
        data_q <= sel_data;
      end
    end
  end

  assign data_out     = data_q;
  assign chan_out     = chan_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Self-checking bench: two instances (3 ch / dwell 3 and 4 ch / dwell 1) against a cycle model.
module tb_mux_nto1_scan;

  logic        clk;
  logic        rstn, mode, hold;
  logic [1:0]  sel;
  logic [11:0] data_a;
  logic [15:0] data_b;
  logic [3:0]  dout_a, dout_b;
  logic [1:0]  chan_a, chan_b;
  logic        pulse_a, pulse_b;

  int total = 0;
  int bad   = 0;

  mux_nto1_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) dut_a (
    .Clock        (clk),
    .Resetn       (rstn),
    .data_in      (data_a),
    .sel_in       (sel),
    .mode         (mode),
    .hold         (hold),
    .data_out     (dout_a),
    .chan_out     (chan_a),
    .switch_pulse (pulse_a)
  );

  mux_nto1_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) dut_b (
    .Clock        (clk),
    .Resetn       (rstn),
    .data_in      (data_b),
    .sel_in       (sel),
    .mode         (mode),
    .hold         (hold),
    .data_out     (dout_b),
    .chan_out     (chan_b),
    .switch_pulse (pulse_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: channel index, cycles spent on it, and whether scanning/frozen.
  int nchan[2] = '{3, 4};
  int dwell[2] = '{3, 1};
  int m_chan[2], m_elapsed[2], m_out[2];
  bit m_scan[2], m_frozen[2], m_pulse[2];
  bit model_ok = 1'b0;

  function automatic int chan_data(input int k, input int c);
    if (k == 0) return int'((data_a >> (4 * c)) & 12'hF);
    return int'((data_b >> (4 * c)) & 16'hF);
  endfunction

  function automatic void model_step(input int k);
    int prev;
    prev = m_chan[k];
    if (!rstn) begin
      m_chan[k] = 0; m_elapsed[k] = 0; m_out[k] = 0;
      m_scan[k] = 0; m_frozen[k] = 0; m_pulse[k] = 0;
      model_ok = 1'b1;
    end else if (hold) begin
      m_frozen[k] = 1;
      m_pulse[k]  = 0;
    end else begin
      if (mode) begin
        if (!m_scan[k] && !m_frozen[k]) begin
          m_elapsed[k] = 0;
        end else if (m_elapsed[k] == dwell[k] - 1) begin
          m_elapsed[k] = 0;
          m_chan[k] = (m_chan[k] + 1) % nchan[k];
        end else begin
          m_elapsed[k]++;
        end
        m_scan[k] = 1;
      end else begin
        if (int'(sel) < nchan[k]) m_chan[k] = int'(sel);
        m_scan[k] = 0;
      end
      m_frozen[k] = 0;
      m_out[k]    = chan_data(k, m_chan[k]);
      m_pulse[k]  = (m_chan[k] != prev);
    end
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Compare both instances against the model every cycle once it has seen reset.
  always @(negedge clk) begin
    if (model_ok) begin
      check("a_data", 32'(dout_a), 32'(m_out[0]));
      check("a_chan", 32'(chan_a), 32'(m_chan[0]));
      check("a_pulse", 32'(pulse_a), 32'(m_pulse[0]));
      check("b_data", 32'(dout_b), 32'(m_out[1]));
      check("b_chan", 32'(chan_b), 32'(m_chan[1]));
      check("b_pulse", 32'(pulse_b), 32'(m_pulse[1]));
    end
  end

  logic [3:0] vals_a [3];

  initial begin
    vals_a = '{4'hA, 4'hB, 4'hC};
    rstn = 1'b0; mode = 1'b1; hold = 1'b0; sel = 2'd0;
    data_a = 12'hCBA; data_b = 16'h7654;

    // Reset held two edges with scan requested.
    repeat (2) @(negedge clk);
    check("rst_data", 32'(dout_a), 32'd0);
    check("rst_chan", 32'(chan_a), 32'd0);
    check("rst_pulse", 32'(pulse_a), 32'd0);
    check("rst_chan_b", 32'(chan_b), 32'd0);

    // Manual select, then an out-of-range select.
    rstn = 1'b1; mode = 1'b0; sel = 2'd2;
    @(negedge clk);
    check("man_chan", 32'(chan_a), 32'd2);
    check("man_data", 32'(dout_a), 32'hC);
    check("man_pulse", 32'(pulse_a), 32'd1);
    sel = 2'd3;
    @(negedge clk);
    check("oor_chan", 32'(chan_a), 32'd2);
    check("oor_pulse", 32'(pulse_a), 32'd0);
    check("b_sel3_chan", 32'(chan_b), 32'd3);
    check("b_sel3_data", 32'(dout_b), 32'h7);
    sel = 2'd0;
    @(negedge clk);
    check("man0_chan", 32'(chan_a), 32'd0);

    // Scan wrap: three cycles per channel on A, one per channel on B.
    mode = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      check("scan_chan", 32'(chan_a), 32'((i / 3) % 3));
      check("scan_data", 32'(dout_a), 32'(vals_a[(i / 3) % 3]));
      check("scan_pulse", 32'(pulse_a), 32'((i > 0) && (i % 3 == 0)));
      if (i <= 4) begin
        check("b_scan_chan", 32'(chan_b), 32'(i % 4));
        check("b_scan_pulse", 32'(pulse_b), 32'(i > 0));
      end
    end

    // One cycle into channel 1, freeze for ten cycles, then finish the dwell.
    @(negedge clk);
    check("pre_hold_chan", 32'(chan_a), 32'd1);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_chan", 32'(chan_a), 32'd1);
      check("hold_data", 32'(dout_a), 32'hB);
      check("hold_pulse", 32'(pulse_a), 32'd0);
    end
    hold = 1'b0;
    @(negedge clk);
    check("rel1_chan", 32'(chan_a), 32'd1);
    @(negedge clk);
    check("rel2_chan", 32'(chan_a), 32'd2);
    check("rel2_pulse", 32'(pulse_a), 32'd1);

    // Hold and mode change on the same edge: hold wins, mode applies on release.
    hold = 1'b1; mode = 1'b0;
    @(negedge clk);
    check("hm_chan", 32'(chan_a), 32'd2);
    check("hm_pulse", 32'(pulse_a), 32'd0);
    hold = 1'b0; sel = 2'd0;
    @(negedge clk);
    check("hm_rel_chan", 32'(chan_a), 32'd0);
    check("hm_rel_data", 32'(dout_a), 32'hA);
    check("hm_rel_pulse", 32'(pulse_a), 32'd1);
    @(negedge clk);
    check("hm_stay_pulse", 32'(pulse_a), 32'd0);

    // Randomised phase, checked by the model process.
    for (int c = 0; c < 3000; c++) begin
      rstn = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      hold = ($urandom_range(0, 7) == 0);
      sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        data_a = 12'($urandom);
        data_b = 16'($urandom);
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
